uart_num_parser: RTL and testbench

- Sits between the UART receiver and the mode FSMs (setting mode, matrix input mode).
- Converts the raw received byte stream into range-checked decimal values, one pulse per value.
- A mode FSM consumes num_value/num_valid instead of decoding ASCII itself.
- The mode FSM's clear_rx_buffer output drives this block's clear input, which aborts a partial token.

---
 rtl/uart_num_parser_pkg.sv | 29 ++
 rtl/uart_num_parser_ascii_char_class.sv | 24 ++
 rtl/uart_num_parser.sv | 214 +++++++++++++++++++++
 tb/tb_uart_num_parser.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_num_parser_pkg.sv
// Shared constants and types for the UART decimal number parser.
// ASCII codes, error codes and parser state encoding live here so the
// later command decoder can reuse the same definitions.
package uart_num_parser_pkg;

  // Width of one matrix element; the default width of a parsed value.
  localparam int ELEMENT_WIDTH = 8;

  // ASCII characters recognised by the parser.
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;

  // Error codes reported on error_code.
  localparam logic [3:0] ERR_NONE        = 4'd0;
  localparam logic [3:0] ERR_PARSE_CHAR  = 4'd8;
  localparam logic [3:0] ERR_PARSE_RANGE = 4'd9;

  // Token parser states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SKIP  = 2'd2
  } parse_state_t;

endpackage

// File: rtl/uart_num_parser_ascii_char_class.sv
// ascii_char_class: purely combinational classifier for one received byte.
// Flags digits, token terminators (space/CR/LF), end-of-line (CR/LF) and
// the minus sign, and gives the numeric value of a digit character.
module ascii_char_class
  import uart_num_parser_pkg::*;
(
  input  logic [7:0] char_in,
  output logic       is_digit,
  output logic       is_term,
  output logic       is_eol,
  output logic       is_minus,
  output logic [3:0] digit_val
);

  // Decode character classes; '0'..'9' carry their value in the low nibble.
  always_comb begin
    is_digit  = (char_in >= ASCII_0) && (char_in <= ASCII_9);
    is_eol    = (char_in == ASCII_CR) || (char_in == ASCII_LF);
    is_term   = is_eol || (char_in == ASCII_SPACE);
    is_minus  = (char_in == ASCII_MINUS);
    digit_val = is_digit ? char_in[3:0] : 4'd0;
  end

endmodule

// File: rtl/uart_num_parser.sv
// uart_num_parser: turns the raw UART byte stream into range-checked
// decimal values, emitting one num_valid pulse per accepted token.
// Optional build macro: PARSE_NEGATIVE_EN enables a leading '-' sign and
// returns the two's complement of the magnitude on acceptance.
module uart_num_parser
  import uart_num_parser_pkg::*;
#(
  parameter int VALUE_WIDTH = ELEMENT_WIDTH,
  parameter int MAX_DIGITS  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [7:0]             rx_data,
  input  logic                   rx_done,
  input  logic                   clear,
  input  logic [VALUE_WIDTH-1:0] range_max,
  output logic [VALUE_WIDTH-1:0] num_value,
  output logic                   num_valid,
  output logic                   num_is_last,
  output logic                   parse_error,
  output logic [3:0]             error_code,
  output logic                   busy
);

  // Accumulation is done 4 bits wider so acc*10+digit can never wrap
  // before it is compared against range_max.
  localparam int WW = VALUE_WIDTH + 4;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [WW-1:0] TEN = WW'(10);

  parse_state_t           state_reg, state_next;
  logic [VALUE_WIDTH-1:0] acc_reg, acc_next;
  logic [CW-1:0]          count_reg, count_next;
  logic [VALUE_WIDTH-1:0] num_value_reg, num_value_next;
  logic                   num_valid_reg, num_valid_next;
  logic                   num_is_last_reg, num_is_last_next;
  logic                   parse_error_reg, parse_error_next;
  logic [3:0]             error_code_reg, error_code_next;
`ifdef PARSE_NEGATIVE_EN
  logic                   neg_reg, neg_next;
`endif

  logic       is_digit, is_term, is_eol, is_minus;
  logic [3:0] digit_val;
  logic [WW-1:0] acc_wide;
  logic [WW-1:0] digit_wide;
  logic [WW-1:0] range_wide;

  ascii_char_class u_char_class (
    .char_in   (rx_data),
    .is_digit  (is_digit),
    .is_term   (is_term),
    .is_eol    (is_eol),
    .is_minus  (is_minus),
    .digit_val (digit_val)
  );

  // Widened arithmetic for the running value and the range comparison.
  always_comb begin
    digit_wide = WW'(digit_val);
    range_wide = WW'(range_max);
    acc_wide   = (WW'(acc_reg) * TEN) + digit_wide;
  end

  // Next-state and output decode; abort (clear or disable) has top priority.
  always_comb begin
    state_next       = state_reg;
    acc_next         = acc_reg;
    count_next       = count_reg;
    num_value_next   = num_value_reg;
    num_valid_next   = 1'b0;
    num_is_last_next = 1'b0;
    parse_error_next = 1'b0;
    error_code_next  = error_code_reg;
`ifdef PARSE_NEGATIVE_EN
    neg_next         = neg_reg;
`endif

    if (!enable || clear) begin
      state_next      = ST_IDLE;
      acc_next        = '0;
      count_next      = '0;
      error_code_next = ERR_NONE;
`ifdef PARSE_NEGATIVE_EN
      neg_next        = 1'b0;
`endif
    end else if (rx_done) begin
      case (state_reg)
        ST_IDLE: begin
          if (is_digit) begin
            if (digit_wide > range_wide) begin
              parse_error_next = 1'b1;
              error_code_next  = ERR_PARSE_RANGE;
              state_next       = ST_SKIP;
            end else begin
              acc_next   = VALUE_WIDTH'(digit_val);
              count_next = CW'(1);
              state_next = ST_ACCUM;
            end
`ifdef PARSE_NEGATIVE_EN
            neg_next = 1'b0;
          end else if (is_minus) begin
            neg_next   = 1'b1;
            acc_next   = '0;
            count_next = '0;
            state_next = ST_ACCUM;
`else
          end else if (is_minus) begin
            // Without signed support a minus sign is just another bad char.
            parse_error_next = 1'b1;
            error_code_next  = ERR_PARSE_CHAR;
            state_next       = ST_SKIP;
`endif
          end else if (!is_term) begin
            parse_error_next = 1'b1;
            error_code_next  = ERR_PARSE_CHAR;
            state_next       = ST_SKIP;
          end
        end

        ST_ACCUM: begin
          if (is_digit) begin
            if ((count_reg >= CW'(MAX_DIGITS)) || (acc_wide > range_wide)) begin
              parse_error_next = 1'b1;
              error_code_next  = ERR_PARSE_RANGE;
              acc_next         = '0;
              count_next       = '0;
              state_next       = ST_SKIP;
            end else begin
              acc_next   = acc_wide[VALUE_WIDTH-1:0];
              count_next = count_reg + CW'(1);
            end
          end else if (is_term) begin
`ifdef PARSE_NEGATIVE_EN
            if (count_reg == '0) begin
              // A bare '-' followed by a terminator is not a number.
              parse_error_next = 1'b1;
              error_code_next  = ERR_PARSE_CHAR;
            end else begin
              num_value_next   = neg_reg ? ('0 - acc_reg) : acc_reg;
              num_valid_next   = 1'b1;
              num_is_last_next = is_eol;
              error_code_next  = ERR_NONE;
            end
            neg_next = 1'b0;
`else
            num_value_next   = acc_reg;
            num_valid_next   = 1'b1;
            num_is_last_next = is_eol;
            error_code_next  = ERR_NONE;
`endif
            acc_next   = '0;
            count_next = '0;
            state_next = ST_IDLE;
          end else begin
            parse_error_next = 1'b1;
            error_code_next  = ERR_PARSE_CHAR;
            acc_next         = '0;
            count_next       = '0;
            state_next       = ST_SKIP;
          end
        end

        ST_SKIP: begin
          if (is_term) begin
            state_next = ST_IDLE;
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      acc_reg         <= '0;
      count_reg       <= '0;
      num_value_reg   <= '0;
      num_valid_reg   <= 1'b0;
      num_is_last_reg <= 1'b0;
      parse_error_reg <= 1'b0;
      error_code_reg  <= ERR_NONE;
`ifdef PARSE_NEGATIVE_EN
      neg_reg         <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      acc_reg         <= acc_next;
      count_reg       <= count_next;
      num_value_reg   <= num_value_next;
      num_valid_reg   <= num_valid_next;
      num_is_last_reg <= num_is_last_next;
      parse_error_reg <= parse_error_next;
      error_code_reg  <= error_code_next;
`ifdef PARSE_NEGATIVE_EN
      neg_reg         <= neg_next;
`endif
    end
  end

  assign num_value   = num_value_reg;
  assign num_valid   = num_valid_reg;
  assign num_is_last = num_is_last_reg;
  assign parse_error = parse_error_reg;
  assign error_code  = error_code_reg;
  assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_num_parser.sv
// Scoreboard bench for uart_num_parser: stimulus pushes the expected pulse
// (value or error, plus the cycle it must appear in) into a queue; a monitor
// pops and compares whenever num_valid or parse_error is seen.
module tb_uart_num_parser;
  import uart_num_parser_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] range_max = 8'd0;
  logic [7:0] num_value;
  logic       num_valid;
  logic       num_is_last;
  logic       parse_error;
  logic [3:0] error_code;
  logic       busy;

  uart_num_parser #(.VALUE_WIDTH(8), .MAX_DIGITS(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .clear       (clear),
    .range_max   (range_max),
    .num_value   (num_value),
    .num_valid   (num_valid),
    .num_is_last (num_is_last),
    .parse_error (parse_error),
    .error_code  (error_code),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] val;
    bit         last;
    logic [3:0] code;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Expectation pushers: called at the negedge where the causing byte is driven.
  task automatic exp_val(input logic [7:0] v, input bit last);
    exp_t e;
    e.is_err = 1'b0; e.val = v; e.last = last; e.code = ERR_NONE; e.due = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic exp_err(input logic [3:0] code);
    exp_t e;
    e.is_err = 1'b1; e.val = 8'd0; e.last = 1'b0; e.code = code; e.due = cyc + 1;
    exp_q.push_back(e);
  endtask

  // put leaves rx_done high so consecutive puts form a back-to-back burst.
  task automatic put(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
  endtask

  task automatic gap();
    rx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    put(b);
    gap();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("check %s: %0d ok", name, act);
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (rst_n && (num_valid || parse_error)) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b value=%0d code=%0d at cycle %0d, required no pulse",
                 num_valid, parse_error, num_value, error_code, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.is_err)
          ok = parse_error && !num_valid && (error_code == e.code) && (cyc == e.due);
        else
          ok = num_valid && !parse_error && (num_value == e.val) &&
               (num_is_last == e.last) && (error_code == ERR_NONE) && (cyc == e.due);
        if (!ok) begin
          n_bad++;
          $display("FAIL pulse: got valid=%0b err=%0b value=%0d last=%0b code=%0d cycle=%0d, required %s value=%0d last=%0b code=%0d cycle=%0d",
                   num_valid, parse_error, num_value, num_is_last, error_code, cyc,
                   e.is_err ? "error" : "value", e.val, e.last, e.code, e.due);
        end else begin
          $display("txn %s value=%0d last=%0b code=%0d cycle=%0d ok",
                   e.is_err ? "error" : "value", num_value, num_is_last, error_code, cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_num_value", 32'(num_value), 32'd0);
    chk("reset_num_valid", 32'(num_valid), 32'd0);
    chk("reset_parse_error", 32'(parse_error), 32'd0);
    chk("reset_error_code", 32'(error_code), 32'(ERR_NONE));
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    // "3",CR with range 9 -> 3, end of line
    range_max = 8'd9;
    send(8'h33);
    chk("busy_in_accum", 32'(busy), 32'd1);
    exp_val(8'd3, 1'b1); send(ASCII_CR);
    chk("busy_after_accept", 32'(busy), 32'd0);

    // "125 7",LF with range 200
    range_max = 8'd200;
    send(8'h31); send(8'h32); send(8'h35);
    exp_val(8'd125, 1'b0); send(ASCII_SPACE);
    send(8'h37);
    exp_val(8'd7, 1'b1); send(ASCII_LF);
    chk("num_value_held", 32'(num_value), 32'd7);

    // "12 " with range 9 -> range error on '2', then "4",CR
    range_max = 8'd9;
    send(8'h31);
    exp_err(ERR_PARSE_RANGE); send(8'h32);
    send(ASCII_SPACE);
    chk("range_code_sticky", 32'(error_code), 32'(ERR_PARSE_RANGE));
    send(8'h34);
    exp_val(8'd4, 1'b1); send(ASCII_CR);
    chk("code_cleared_by_accept", 32'(error_code), 32'(ERR_NONE));

    // "5x9 " -> one char error, skip until space
    send(8'h35);
    exp_err(ERR_PARSE_CHAR); send(8'h78);
    send(8'h39);
    chk("busy_in_skip", 32'(busy), 32'd1);
    send(ASCII_SPACE);
    chk("busy_after_skip", 32'(busy), 32'd0);
    chk("char_code_sticky", 32'(error_code), 32'(ERR_PARSE_CHAR));

    // "8" then clear with rx_done of "6", then "2",CR -> 2
    send(8'h38);
    clear = 1'b1; put(8'h36); clear = 1'b0; gap();
    chk("busy_after_clear", 32'(busy), 32'd0);
    chk("code_after_clear", 32'(error_code), 32'(ERR_NONE));
    send(8'h32);
    exp_val(8'd2, 1'b1); send(ASCII_CR);

    // Digit-count limit and range boundaries
    range_max = 8'd255;
    send(8'h30); send(8'h30); send(8'h31);
    exp_err(ERR_PARSE_RANGE); send(8'h32);
    send(ASCII_SPACE);
    send(8'h32); send(8'h35); send(8'h35);
    exp_val(8'd255, 1'b0); send(ASCII_SPACE);
    send(8'h32); send(8'h35);
    exp_err(ERR_PARSE_RANGE); send(8'h36);
    send(ASCII_LF);
    range_max = 8'd5;
    exp_err(ERR_PARSE_RANGE); send(8'h39);
    send(ASCII_SPACE);
    send(8'h35);
    exp_val(8'd5, 1'b1); send(ASCII_CR);

    // Disable discards a partial token, ignores rx_done and clears error_code
    range_max = 8'd255;
    exp_err(ERR_PARSE_CHAR); send(8'h3F);
    send(ASCII_SPACE);
    send(8'h34);
    enable = 1'b0;
    @(negedge clk);
    chk("busy_when_disabled", 32'(busy), 32'd0);
    chk("code_when_disabled", 32'(error_code), 32'(ERR_NONE));
    send(8'h37);
    send(ASCII_CR);
    enable = 1'b1;
    send(8'h33);
    exp_val(8'd3, 1'b0); send(ASCII_SPACE);

    // Back-to-back bytes, one per cycle
    range_max = 8'd200;
    put(8'h34); put(8'h32);
    exp_val(8'd42, 1'b0); put(ASCII_SPACE);
    put(8'h31);
    exp_val(8'd1, 1'b1); put(ASCII_CR);
    gap();

    // Sign handling
`ifdef PARSE_NEGATIVE_EN
    range_max = 8'd9;
    send(ASCII_MINUS); send(8'h35);
    exp_val(8'hFB, 1'b1); send(ASCII_CR);
    send(ASCII_MINUS);
    exp_err(ERR_PARSE_CHAR); send(ASCII_CR);
    chk("bare_minus_code", 32'(error_code), 32'(ERR_PARSE_CHAR));
    send(8'h33);
    exp_err(ERR_PARSE_CHAR); send(ASCII_MINUS);
    send(ASCII_SPACE);
`else
    range_max = 8'd9;
    exp_err(ERR_PARSE_CHAR); send(ASCII_MINUS);
    send(8'h35);
    send(ASCII_CR);
    chk("minus_invalid_code", 32'(error_code), 32'(ERR_PARSE_CHAR));
`endif
    chk("busy_end", 32'(busy), 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
